nibble_parity_rx: RTL and testbench

NIBBLE_PARITY_RX -- requirements
Module: nibble_parity_rx

---
 rtl/nibble_parity_rx.sv | 108 ++++++++++
 tb/tb_nibble_parity_rx.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/nibble_parity_rx.sv
// Purpose : receives a 7-bit serial frame (start, d3..d0, parity, stop) into a nibble, flags parity/framing errors.
// Latency : dout/dvalid/par_err/frm_err update on the stop-bit sampling edge; dvalid is a 1-cycle pulse.
// Backpressure: none; sin is consumed only on bit_en strobes. Optional err_cnt counter via `define NPR_ERR_CNT_EN.
module nibble_parity_rx #(
  parameter bit ODD_PAR = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sin,
  input  logic       bit_en,
  output logic [3:0] dout,
  output logic       dvalid,
  output logic       par_err,
  output logic       frm_err,
  output logic       busy,
  output logic [7:0] err_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2,
    STOP = 2'd3
  } state_t;

  state_t     state;
  logic [1:0] bit_cnt;
  logic [3:0] shreg;
  logic       par_bit;

  // Parity and stop-bit verdicts for the frame that completes on this strobe.
  logic par_bad;
  logic stop_bad;
  assign par_bad  = ((^shreg) ^ par_bit) != ODD_PAR;
  assign stop_bad = ~sin;

  // Frame FSM: walks start/data/parity/stop on strobes and registers the frame result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= 2'd0;
      shreg   <= 4'd0;
      par_bit <= 1'b0;
      dout    <= 4'd0;
      dvalid  <= 1'b0;
      par_err <= 1'b0;
      frm_err <= 1'b0;
    end else begin
      // Result flags are only meaningful alongside dvalid, so they drop with it.
      dvalid  <= 1'b0;
      par_err <= 1'b0;
      frm_err <= 1'b0;
      if (bit_en) begin
        case (state)
          IDLE: begin
            if (!sin) begin
              state   <= DATA;
              bit_cnt <= 2'd0;
            end
          end
          DATA: begin
            shreg   <= {shreg[2:0], sin};
            bit_cnt <= bit_cnt + 2'd1;
            if (bit_cnt == 2'd3) begin
              state <= PAR;
            end
          end
          PAR: begin
            par_bit <= sin;
            state   <= STOP;
          end
          STOP: begin
            // Always return to IDLE, even on a bad stop bit, so a 0 on the
            // very next strobe is taken as a fresh start bit.
            state   <= IDLE;
            dout    <= shreg;
            dvalid  <= 1'b1;
            par_err <= par_bad;
            frm_err <= stop_bad;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy = (state != IDLE);

`ifdef NPR_ERR_CNT_EN
  logic [7:0] err_cnt_q;
  logic       frame_bad;
  assign frame_bad = bit_en && (state == STOP) && (par_bad || stop_bad);

  // Saturating errored-frame counter; a frame with both errors counts once.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_q <= 8'd0;
    end else if (frame_bad && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_nibble_parity_rx.sv
module tb_nibble_parity_rx;

  logic       clk;
  logic       rst_n;
  logic       sin;
  logic       bit_en;
  logic       bit_en_o;
  logic [3:0] dout,    dout_o;
  logic       dvalid,  dvalid_o;
  logic       par_err, par_err_o;
  logic       frm_err, frm_err_o;
  logic       busy,    busy_o;
  logic [7:0] err_cnt, err_cnt_o;

  int passed = 0;
  int total  = 0;
  int exp_cnt = 0;
  int exp_cnt_o = 0;
  bit use_odd = 1'b0;

  nibble_parity_rx #(.ODD_PAR(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .sin(sin), .bit_en(bit_en),
    .dout(dout), .dvalid(dvalid), .par_err(par_err), .frm_err(frm_err),
    .busy(busy), .err_cnt(err_cnt)
  );

  nibble_parity_rx #(.ODD_PAR(1'b1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .sin(sin), .bit_en(bit_en_o),
    .dout(dout_o), .dvalid(dvalid_o), .par_err(par_err_o), .frm_err(frm_err_o),
    .busy(busy_o), .err_cnt(err_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected counter value after one errored frame.
  function automatic int bump(input int c);
`ifdef NPR_ERR_CNT_EN
    return (c >= 255) ? 255 : c + 1;
`else
    return c;
`endif
  endfunction

  // One strobe: bit_en high across exactly one rising edge, then a quiet cycle.
  task automatic strobe(input logic b);
    @(negedge clk);
    sin = b;
    if (use_odd) bit_en_o = 1'b1; else bit_en = 1'b1;
    @(negedge clk);
    bit_en   = 1'b0;
    bit_en_o = 1'b0;
    sin      = 1'b1;
  endtask

  // Frame with gaps between strobes; f[6] goes first. Returns at the negedge after the stop edge.
  task automatic send_frame(input logic [6:0] f);
    for (int i = 6; i >= 0; i--) strobe(f[i]);
  endtask

  // Frame with bit_en held high every cycle.
  task automatic send_fast(input logic [6:0] f);
    for (int i = 6; i >= 0; i--) begin
      @(negedge clk);
      sin    = f[i];
      bit_en = 1'b1;
    end
    @(negedge clk);
    bit_en = 1'b0;
    sin    = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; sin = 1'b0; bit_en = 1'b1; bit_en_o = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else passed++;
    rst_n = 1'b1; bit_en = 1'b0; bit_en_o = 1'b0; sin = 1'b1;
    @(negedge clk);
    total++; if (dout !== 4'd0) $display("FAIL rst_dout got %b exp 0000", dout); else passed++;
    total++; if (dvalid !== 1'b0) $display("FAIL rst_dvalid got %b exp 0", dvalid); else passed++;
    total++; if (par_err !== 1'b0) $display("FAIL rst_par_err got %b exp 0", par_err); else passed++;
    total++; if (frm_err !== 1'b0) $display("FAIL rst_frm_err got %b exp 0", frm_err); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy2 got %b exp 0", busy); else passed++;
    total++; if (err_cnt !== 8'd0) $display("FAIL rst_err_cnt got %0d exp 0", err_cnt); else passed++;
  endtask

  task automatic test_good_frame;
    strobe(1'b0);
    total++; if (busy !== 1'b1) $display("FAIL good_busy got %b exp 1", busy); else passed++;
    strobe(1'b1); strobe(1'b0);
    // Idle cycles with sin low and no strobe must not advance anything.
    sin = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b1 || dvalid !== 1'b0) $display("FAIL hold_state got busy=%b dvalid=%b exp 1/0", busy, dvalid); else passed++;
    strobe(1'b1); strobe(1'b1); strobe(1'b1); strobe(1'b1);
    total++; if (dvalid !== 1'b1) $display("FAIL good_dvalid got %b exp 1", dvalid); else passed++;
    total++; if (dout !== 4'b1011) $display("FAIL good_dout got %b exp 1011", dout); else passed++;
    total++; if (par_err !== 1'b0 || frm_err !== 1'b0) $display("FAIL good_errs got %b%b exp 00", par_err, frm_err); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL good_idle got %b exp 0", busy); else passed++;
    @(negedge clk);
    total++; if (dvalid !== 1'b0) $display("FAIL good_pulse got %b exp 0", dvalid); else passed++;
    total++; if (dout !== 4'b1011) $display("FAIL good_dout_hold got %b exp 1011", dout); else passed++;
  endtask

  task automatic test_parity_err;
    send_frame(7'b0101101);
    exp_cnt = bump(exp_cnt);
    total++; if (dvalid !== 1'b1 || dout !== 4'b1011) $display("FAIL perr_frame got dvalid=%b dout=%b exp 1/1011", dvalid, dout); else passed++;
    total++; if (par_err !== 1'b1 || frm_err !== 1'b0) $display("FAIL perr_flags got %b%b exp 10", par_err, frm_err); else passed++;
    total++; if (err_cnt !== exp_cnt[7:0]) $display("FAIL perr_cnt got %0d exp %0d", err_cnt, exp_cnt); else passed++;
    @(negedge clk);
    total++; if (par_err !== 1'b0) $display("FAIL perr_qual got %b exp 0", par_err); else passed++;
  endtask

  task automatic test_frame_err;
    send_frame(7'b0000000);
    exp_cnt = bump(exp_cnt);
    total++; if (dvalid !== 1'b1 || frm_err !== 1'b1 || par_err !== 1'b0) $display("FAIL ferr_flags got v=%b f=%b p=%b exp 1/1/0", dvalid, frm_err, par_err); else passed++;
    total++; if (err_cnt !== exp_cnt[7:0]) $display("FAIL ferr_cnt got %0d exp %0d", err_cnt, exp_cnt); else passed++;
    strobe(1'b0);
    total++; if (busy !== 1'b1) $display("FAIL ferr_restart got %b exp 1", busy); else passed++;
    strobe(1'b0); strobe(1'b0); strobe(1'b0); strobe(1'b0); strobe(1'b0); strobe(1'b1);
    total++; if (dvalid !== 1'b1 || dout !== 4'b0000 || frm_err !== 1'b0 || par_err !== 1'b0) $display("FAIL ferr_next got v=%b d=%b f=%b p=%b exp 1/0000/0/0", dvalid, dout, frm_err, par_err); else passed++;
    @(negedge clk);
    total++; if (frm_err !== 1'b0) $display("FAIL ferr_qual got %b exp 0", frm_err); else passed++;
  endtask

  task automatic test_odd_parity;
    use_odd = 1'b1;
    send_frame(7'b0000011);
    total++; if (dvalid_o !== 1'b1 || par_err_o !== 1'b0 || dout_o !== 4'b0000) $display("FAIL odd_good got v=%b p=%b d=%b exp 1/0/0000", dvalid_o, par_err_o, dout_o); else passed++;
    send_frame(7'b0000001);
    exp_cnt_o = bump(exp_cnt_o);
    total++; if (dvalid_o !== 1'b1 || par_err_o !== 1'b1 || frm_err_o !== 1'b0) $display("FAIL odd_bad got v=%b p=%b f=%b exp 1/1/0", dvalid_o, par_err_o, frm_err_o); else passed++;
    total++; if (err_cnt_o !== exp_cnt_o[7:0]) $display("FAIL odd_cnt got %0d exp %0d", err_cnt_o, exp_cnt_o); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL odd_isolation got %b exp 0", busy); else passed++;
    use_odd = 1'b0;
  endtask

  task automatic test_reset_mid;
    strobe(1'b0); strobe(1'b1); strobe(1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
    exp_cnt_o = 0;
    total++; if (busy !== 1'b0 || dvalid !== 1'b0) $display("FAIL midrst_state got busy=%b dvalid=%b exp 0/0", busy, dvalid); else passed++;
    total++; if (err_cnt !== 8'd0 || dout !== 4'd0) $display("FAIL midrst_clear got cnt=%0d dout=%b exp 0/0000", err_cnt, dout); else passed++;
    send_frame(7'b0011001);
    total++; if (dvalid !== 1'b1 || dout !== 4'b0110 || par_err !== 1'b0 || frm_err !== 1'b0) $display("FAIL midrst_frame got v=%b d=%b p=%b f=%b exp 1/0110/0/0", dvalid, dout, par_err, frm_err); else passed++;
  endtask

  task automatic test_back_to_back;
    logic [13:0] bits;
    bits = {7'b0110001, 7'b0000111};
    for (int i = 13; i >= 0; i--) begin
      @(negedge clk);
      if (i == 6) begin
        total++; if (dvalid !== 1'b1 || dout !== 4'b1100 || par_err !== 1'b0) $display("FAIL b2b_first got v=%b d=%b p=%b exp 1/1100/0", dvalid, dout, par_err); else passed++;
      end
      if (i == 5) begin
        total++; if (dvalid !== 1'b0 || busy !== 1'b1) $display("FAIL b2b_start got v=%b busy=%b exp 0/1", dvalid, busy); else passed++;
      end
      sin    = bits[i];
      bit_en = 1'b1;
    end
    @(negedge clk);
    bit_en = 1'b0;
    sin    = 1'b1;
    total++; if (dvalid !== 1'b1 || dout !== 4'b0001 || par_err !== 1'b0 || frm_err !== 1'b0) $display("FAIL b2b_second got v=%b d=%b p=%b f=%b exp 1/0001/0/0", dvalid, dout, par_err, frm_err); else passed++;
  endtask

  task automatic test_saturation;
    for (int n = 0; n < 260; n++) begin
      send_fast(7'b0100001);
      exp_cnt = bump(exp_cnt);
    end
    total++; if (err_cnt !== exp_cnt[7:0]) $display("FAIL sat_cnt got %0d exp %0d", err_cnt, exp_cnt); else passed++;
    total++; if (par_err !== 1'b1 || dout !== 4'b1000) $display("FAIL sat_frame got p=%b d=%b exp 1/1000", par_err, dout); else passed++;
    send_fast(7'b0100001);
    exp_cnt = bump(exp_cnt);
    total++; if (err_cnt !== exp_cnt[7:0]) $display("FAIL sat_hold got %0d exp %0d", err_cnt, exp_cnt); else passed++;
  endtask

  initial begin
    rst_n = 1'b0; sin = 1'b1; bit_en = 1'b0; bit_en_o = 1'b0;
    test_reset;
    test_good_frame;
    test_parity_err;
    test_frame_err;
    test_odd_parity;
    test_reset_mid;
    test_back_to_back;
    test_saturation;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
